// File: rtl/alu_pkg.sv
// Shared constants for the ALU result stage: NZCV flag bit positions and entry packing width.
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAG_W = 4;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RD_W  = 5;

    // Packed entry layout, MSB first: {set_flags, flags, rd, result}.
    function automatic int entry_width(input int width, input int rd_w);
        return width + rd_w + FLAG_W + 1;
    endfunction

    localparam int ENTRY_W = entry_width(DEF_WIDTH, DEF_RD_W);

endpackage

// File: rtl/result_fifo2.sv
// Two-entry register FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
module result_fifo2
    import alu_pkg::*;
#(
    parameter int DW = ENTRY_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    // NOTE: the storage is reset because the head is visible on the outputs and must read 0, not X, after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // When empty, the most recently retired entry still sits behind rd_ptr,
    // so showing it keeps the outputs stable without a separate holding register.
    assign rdata = mem[(count == 2'd0) ? ~rd_ptr : rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry valid/ready buffer plus architectural NZCV register.
// Optional sticky overflow flag when ALU_STICKY_OV_EN is defined (adds ClrSticky/StickyV).
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RD_W  = DEF_RD_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  InResult,
    input  logic [FLAG_W-1:0] InFlags,
    input  logic [RD_W-1:0]   InRd,
    input  logic              InSetFlags,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  OutResult,
    output logic [RD_W-1:0]   OutRd,
    output logic [FLAG_W-1:0] OutFlags,
    output logic [FLAG_W-1:0] Flags,
`ifdef ALU_STICKY_OV_EN
    input  logic              ClrSticky,
    output logic              StickyV,
`endif
    output logic [1:0]        Count
);

    localparam int EW = entry_width(WIDTH, RD_W);

    logic          push;
    logic          pop;
    logic          head_set_flags;
    logic [EW-1:0] head;

    assign InReady  = (Count != 2'd2) & ~Rst;
    assign OutValid = (Count != 2'd0);
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;

    result_fifo2 #(.DW(EW)) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .pop   (pop),
        .wdata ({InSetFlags, InFlags, InRd, InResult}),
        .rdata (head),
        .count (Count)
    );

    assign {head_set_flags, OutFlags, OutRd, OutResult} = head;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Flags <= '0;
        end else if (pop && head_set_flags) begin
            Flags <= OutFlags;
        end
    end

`ifdef ALU_STICKY_OV_EN
    // Overflow is recorded on retire regardless of SetFlags; a new set beats a clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StickyV <= 1'b0;
        end else if (pop && OutFlags[FLAG_V]) begin
            StickyV <= 1'b1;
        end else if (ClrSticky) begin
            StickyV <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic,
// scored by a queue-based reference model in a negedge monitor.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int RD_W  = 5;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [RD_W-1:0]  rd;
        logic [3:0]       fl;
        logic             sf;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [WIDTH-1:0] InResult = '0;
    logic [3:0]       InFlags = '0;
    logic [RD_W-1:0]  InRd = '0;
    logic             InSetFlags = 1'b0;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic [WIDTH-1:0] OutResult;
    logic [RD_W-1:0]  OutRd;
    logic [3:0]       OutFlags;
    logic [3:0]       Flags;
    logic [1:0]       Count;
`ifdef ALU_STICKY_OV_EN
    logic             ClrSticky = 1'b0;
    logic             StickyV;
`endif

    alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .InResult   (InResult),
        .InFlags    (InFlags),
        .InRd       (InRd),
        .InSetFlags (InSetFlags),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutResult  (OutResult),
        .OutRd      (OutRd),
        .OutFlags   (OutFlags),
        .Flags      (Flags),
`ifdef ALU_STICKY_OV_EN
        .ClrSticky  (ClrSticky),
        .StickyV    (StickyV),
`endif
        .Count      (Count)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of accepted entries, the last retired entry,
    // the architectural flag value and the sticky overflow bit.
    exp_t       sb[$];
    exp_t       last_out = '{res: '0, rd: '0, fl: '0, sf: 1'b0};
    logic [3:0] m_flags  = 4'b0000;
    logic       m_sticky = 1'b0;

    task automatic model_reset();
        sb.delete();
        last_out = '{res: '0, rd: '0, fl: '0, sf: 1'b0};
        m_flags  = 4'b0000;
        m_sticky = 1'b0;
    endtask

    always @(negedge Clk) begin
        exp_t h;
        bit   do_push;
        bit   do_pop;
        if (!Rst) begin
            h = (sb.size() != 0) ? sb[0] : last_out;
            check("count",      Count,     sb.size());
            check("in_ready",   InReady,   sb.size() != 2);
            check("out_valid",  OutValid,  sb.size() != 0);
            check("arch_flags", Flags,     m_flags);
            check("out_result", OutResult, h.res);
            check("out_rd",     OutRd,     h.rd);
            check("out_flags",  OutFlags,  h.fl);
`ifdef ALU_STICKY_OV_EN
            check("sticky_v",   StickyV,   m_sticky);
`endif
            do_pop  = (sb.size() != 0) && OutReady;
            do_push = InValid && (sb.size() < 2);
            if (do_pop) begin
                h = sb.pop_front();
                last_out = h;
                if (h.sf) m_flags = h.fl;
`ifdef ALU_STICKY_OV_EN
                if (h.fl[FLAG_V]) m_sticky = 1'b1;
                else if (ClrSticky) m_sticky = 1'b0;
`endif
            end
`ifdef ALU_STICKY_OV_EN
            else if (ClrSticky) begin
                m_sticky = 1'b0;
            end
`endif
            if (do_push) begin
                sb.push_back('{res: InResult, rd: InRd, fl: InFlags, sf: InSetFlags});
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] r, input logic [3:0] f, input logic [RD_W-1:0] rd,
                        input logic sf, input logic ordy);
        InValid    = 1'b1;
        InResult   = r;
        InFlags    = f;
        InRd       = rd;
        InSetFlags = sf;
        OutReady   = ordy;
        @(posedge Clk); #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        InValid  = 1'b0;
        OutReady = ordy;
        repeat (n) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        while (sb.size() != 0 && n < 10) begin
            @(posedge Clk); #1;
            n++;
        end
        check("drain_done", sb.size(), 0);
    endtask

    initial begin
        bit acc;

        // Reset state
        #12;
        check("rst_count",     Count,     0);
        check("rst_out_valid", OutValid,  0);
        check("rst_in_ready",  InReady,   0);
        check("rst_flags",     Flags,     0);
        check("rst_result",    OutResult, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;

        // 1: single push, one-cycle latency, then retire
        send(32'd35, 4'b0000, 5'd3, 1'b0, 1'b1);
        InValid = 1'b0;
        check("t1_valid",  OutValid,  1);
        check("t1_result", OutResult, 35);
        check("t1_rd",     OutRd,     3);
        @(posedge Clk); #1;
        check("t1_count",  Count,     0);
        check("t1_hold",   OutResult, 35);

        // 2: fill to two, third push ignored, ordered drain
        send(32'd1, 4'b0000, 5'd1, 1'b0, 1'b0);
        send(32'd2, 4'b0000, 5'd2, 1'b0, 1'b0);
        send(32'd3, 4'b0000, 5'd3, 1'b0, 1'b0);
        InValid = 1'b0;
        check("t2_count_full", Count,   2);
        check("t2_in_ready",   InReady, 0);
        OutReady = 1'b1;
        check("t2_first",  OutResult, 1);
        @(posedge Clk); #1;
        check("t2_second", OutResult, 2);
        @(posedge Clk); #1;
        check("t2_empty",  Count,     0);

        // 3: simultaneous push and pop at Count=1
        send(32'd7, 4'b0010, 5'd7, 1'b0, 1'b0);
        send(32'd8, 4'b0010, 5'd8, 1'b0, 1'b1);
        InValid = 1'b0;
        check("t3_count", Count,     1);
        check("t3_head",  OutResult, 8);
        drain();

        // 4: only the SetFlags entry updates the architectural flags
        check("t4_flags_before", Flags, 4'b0000);
        send(32'hFFFF_FFFB, 4'b1000, 5'd1, 1'b1, 1'b0);
        send(32'h0,         4'b0100, 5'd2, 1'b0, 1'b0);
        drain();
        check("t4_flags", Flags, 4'b1000);

        // 5: asynchronous reset mid-cycle with the buffer full
        send(32'd11, 4'b0011, 5'd4, 1'b1, 1'b0);
        send(32'd12, 4'b0011, 5'd5, 1'b1, 1'b0);
        InValid = 1'b0;
        check("t5_full", Count, 2);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check("t5_out_valid", OutValid,  0);
        check("t5_flags",     Flags,     0);
        check("t5_count",     Count,     0);
        check("t5_in_ready",  InReady,   0);
        check("t5_result",    OutResult, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;

`ifdef ALU_STICKY_OV_EN
        // 6: sticky overflow set on retire regardless of SetFlags; set beats clear
        send(32'd9, 4'b0001, 5'd4, 1'b0, 1'b1);
        idle(1'b1, 1);
        check("t6_sticky_set", StickyV, 1);
        check("t6_flags_held", Flags,   0);
        send(32'd10, 4'b0001, 5'd6, 1'b0, 1'b0);
        InValid   = 1'b0;
        ClrSticky = 1'b1;
        OutReady  = 1'b1;
        @(posedge Clk); #1;
        check("t6_set_wins", StickyV, 1);
        @(posedge Clk); #1;
        check("t6_cleared",  StickyV, 0);
        ClrSticky = 1'b0;
`endif

        // Random traffic; upstream holds its data while stalled.
        acc = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!InValid || acc) begin
                InValid    = ($urandom_range(0, 3) != 0);
                InResult   = $urandom();
                InFlags    = 4'($urandom_range(0, 15));
                InRd       = RD_W'($urandom_range(0, 31));
                InSetFlags = $urandom_range(0, 1) != 0;
            end
            OutReady = ($urandom_range(0, 2) != 0);
`ifdef ALU_STICKY_OV_EN
            ClrSticky = ($urandom_range(0, 7) == 0);
`endif
            acc = InValid && InReady;
            @(posedge Clk); #1;
        end
`ifdef ALU_STICKY_OV_EN
        ClrSticky = 1'b0;
`endif
        drain();
        @(negedge Clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
